spi_responder: RTL and testbench

- SPI mode-0 peripheral (responder) side: the far end of the link whose SCLK comes from the team's SPI clock generator.
- Sits in the system clock domain and oversamples the external sclk, cs_n and mosi pins.
- Deserialises MOSI words MSB-first and presents each one with a single-cycle valid strobe.
- Serialises MISO words supplied through a one-entry valid/ready holding buffer.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_input_sync.sv | 44 ++++
 rtl/spi_responder.sv | 213 +++++++++++++++++++++
 tb/tb_spi_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Definitions shared by the SPI clock generator, the responder and the
// future master: default word width, underrun word, FSM state encoding and
// the SPI mode constants (mode 0: CPOL=0, CPHA=0).
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_DATA_WIDTH  = 8;
  localparam int SPI_SYNC_STAGES = 2;
  localparam logic [SPI_DATA_WIDTH-1:0] SPI_DEFAULT_TX = 8'h00;

  // Mode 0: sclk idles low, data sampled on rise and changed on fall.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  // Width of a counter that indexes bit positions 0..w-1.
  function automatic int spi_count_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// -----------------------------------------------------------------------------
// spi_input_sync
// Brings one asynchronous pin into the clock domain through STAGES flops,
// then keeps one extra flop of history to produce single-cycle rise/fall
// pulses.
//
// Ports:
//   clock   system clock
//   reset   asynchronous active-low reset (chain forced to IDLE_VAL)
//   pin_i   asynchronous input pin
//   sync_o  synchronised pin level
//   rise_o  one-cycle pulse on a synchronised 0->1 transition
//   fall_o  one-cycle pulse on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module spi_input_sync #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= {STAGES{IDLE_VAL}};
      prev_q <= IDLE_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_responder.sv
// -----------------------------------------------------------------------------
// spi_responder
// SPI mode-0 responder running in the system clock domain. sclk, cs_n and
// mosi are oversampled; MOSI words are assembled MSB-first and presented
// with a one-cycle rx_valid strobe, MISO words come from a one-entry
// valid/ready holding buffer (DEFAULT_TX is sent when it is empty).
//
// Ports:
//   clock, reset          system clock, asynchronous active-low reset
//   sclk, cs_n, mosi      SPI pins from the master (asynchronous)
//   miso, miso_oe         SPI data out and pad output enable
//   tx_data/valid/ready   holding-buffer write handshake
//   rx_data, rx_valid     last received word and its update strobe
//   tx_underrun           strobe: DEFAULT_TX loaded, buffer was empty
//   busy                  a transaction is in progress
// -----------------------------------------------------------------------------
module spi_responder
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int                    SYNC_STAGES = SPI_SYNC_STAGES,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = DATA_WIDTH'(SPI_DEFAULT_TX)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int              CW       = spi_count_width(DATA_WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);

  // ---------------------------------------------------------------------------
  // Pin synchronisers
  // ---------------------------------------------------------------------------
  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  spi_input_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sclk (
    .clock (clock),
    .reset (reset),
    .pin_i (sclk),
    .sync_o(sclk_sync),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_cs (
    .clock (clock),
    .reset (reset),
    .pin_i (cs_n),
    .sync_o(cs_sync),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_mosi (
    .clock (clock),
    .reset (reset),
    .pin_i (mosi),
    .sync_o(mosi_sync),
    .rise_o(mosi_rise),
    .fall_o(mosi_fall)
  );

  // Only the edges of sclk/cs_n and the level of mosi are needed here.
  logic unused_sync;
  assign unused_sync = ^{sclk_sync, cs_sync, mosi_rise, mosi_fall};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  spi_state_e            state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  word_done_q, word_done_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  underrun_q, underrun_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;

  logic                  consume;
  logic [DATA_WIDTH-1:0] rx_word;

  assign rx_word = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      word_done_q <= 1'b0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_shift_q  <= '0;
      underrun_q  <= 1'b0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      word_done_q <= word_done_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_shift_q  <= tx_shift_d;
      underrun_q  <= underrun_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    word_done_d = word_done_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_shift_d  = tx_shift_q;
    underrun_d  = 1'b0;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    consume     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // sclk edges are deliberately ignored while deselected.
        if (cs_fall) begin
          state_d     = ST_ACTIVE;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
          rx_shift_d  = '0;
          consume     = 1'b1;
        end
      end

      ST_ACTIVE: begin
        // cs_n rise takes priority over any sclk edge in the same cycle, so
        // a word completing exactly at deselect is discarded.
        if (cs_rise) begin
          state_d     = ST_IDLE;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
          tx_shift_d  = '0;
        end else if (sclk_rise) begin
          rx_shift_d = rx_word;
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d   = rx_word;
            rx_valid_d  = 1'b1;
            bit_cnt_d   = '0;
            word_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (word_done_q) begin
            // Next word goes out back to back with no gap bit.
            word_done_d = 1'b0;
            consume     = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Load the shifter from the pre-cycle buffer contents.
    if (consume) begin
      if (buf_full_q) begin
        tx_shift_d = buf_q;
        buf_full_d = 1'b0;
      end else begin
        tx_shift_d = DEFAULT_TX;
        underrun_d = 1'b1;
      end
    end

    // Accept uses the pre-cycle ready, so a word written into an empty
    // buffer during an underrun load waits for the following word slot.
    if (tx_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign miso        = tx_shift_q[DATA_WIDTH-1];
  assign miso_oe     = (state_q == ST_ACTIVE);
  assign busy        = (state_q == ST_ACTIVE);
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_responder
// Directed bench for spi_responder: a mode-0 master model drives sclk/cs_n/
// mosi and captures miso on each sclk rise; a monitor logs rx_valid words
// and tx_underrun pulses. Each frame ends with sclk falling in the same
// instant cs_n rises, so the final sclk fall is swallowed by deselect and
// does not start another word load.
// -----------------------------------------------------------------------------
module tb_spi_responder;

  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int HALF = 16;

  logic          clock;
  logic          reset;
  logic          sclk;
  logic          cs_n;
  logic          mosi;
  logic          miso;
  logic          miso_oe;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          tx_underrun;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] m_tx   [0:63];   // words the master sends on mosi
  logic [DW-1:0] m_rx   [0:63];   // words the master captured on miso
  logic [DW-1:0] exp_tx [0:63];   // words written into the tx buffer
  logic [DW-1:0] rx_log [0:255];
  int            rx_wr  = 0;
  int            ur_cnt = 0;

  spi_responder #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SYNC),
    .DEFAULT_TX (8'h00)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_underrun(tx_underrun),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Logs every cycle rx_valid / tx_underrun is high; a stretched pulse
  // shows up as an extra entry.
  always @(negedge clock) begin
    if (reset) begin
      if (rx_valid) begin
        rx_log[rx_wr[7:0]] <= rx_data;
        rx_wr <= rx_wr + 1;
      end
      if (tx_underrun) ur_cnt <= ur_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Writes one word into the holding buffer, waiting (bounded) for ready.
  task automatic push_tx(input logic [DW-1:0] d);
    int n;
    n        = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (!tx_ready) check("tx_ready_timeout", 32'd0, 32'd1);
    @(negedge clock);
    tx_valid = 1'b0;
    $display("tx write 0x%02h", d);
  endtask

  // One bit: sclk low with mosi set, master samples miso, then sclk high.
  task automatic sclk_bit(input logic b, input int half, output logic cap);
    sclk = 1'b0;
    mosi = b;
    wait_clks(half);
    cap  = miso;
    sclk = 1'b1;
    wait_clks(half);
  endtask

  // Full cs_n window of nwords words; stop_bits>0 aborts after that many bits.
  task automatic spi_frame(input int nwords, input int half, input int stop_bits);
    int   bits;
    logic cap;
    bits = 0;
    cs_n = 1'b0;
    for (int w = 0; w < nwords; w++) begin
      for (int b = DW - 1; b >= 0; b--) begin
        if (stop_bits == 0 || bits < stop_bits) begin
          sclk_bit(m_tx[w][b], half, cap);
          m_rx[w][b] = cap;
          bits++;
        end
      end
    end
    sclk = 1'b0;
    cs_n = 1'b1;
    wait_clks(half + 6);
    $display("spi frame: %0d words, %0d bits, half=%0d, mosi[0]=0x%02h miso[0]=0x%02h",
             nwords, bits, half, m_tx[0], m_rx[0]);
  endtask

  int   rx_base;
  int   ur_base;
  logic cap_dummy;
  logic [DW-1:0] tmp;

  initial begin
    reset    = 1'b0;
    sclk     = 1'b0;
    cs_n     = 1'b1;
    mosi     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    wait_clks(3);

    // ---- reset values ----
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_underrun", tx_underrun, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    wait_clks(5);

    // ---- single word ----
    rx_base = rx_wr; ur_base = ur_cnt;
    push_tx(8'hA5);
    check("single_tx_ready_full", tx_ready, 0);
    m_tx[0] = 8'h3C;
    fork
      spi_frame(1, HALF, 0);
      begin
        wait_clks(10);
        check("single_busy", busy, 1);
        check("single_miso_oe", miso_oe, 1);
      end
    join
    check("single_miso", m_rx[0], 8'hA5);
    check("single_rx_count", rx_wr - rx_base, 1);
    check("single_rx_data", rx_log[rx_base], 8'h3C);
    check("single_underrun", ur_cnt - ur_base, 0);
    check("single_idle_busy", busy, 0);

    // ---- streaming ----
    rx_base = rx_wr; ur_base = ur_cnt;
    push_tx(8'h11);
    m_tx[0] = 8'hF0; m_tx[1] = 8'h0F;
    fork
      spi_frame(2, HALF, 0);
      push_tx(8'h22);
    join
    check("stream_miso0", m_rx[0], 8'h11);
    check("stream_miso1", m_rx[1], 8'h22);
    check("stream_rx_count", rx_wr - rx_base, 2);
    check("stream_rx0", rx_log[rx_base], 8'hF0);
    check("stream_rx1", rx_log[rx_base+1], 8'h0F);
    check("stream_underrun", ur_cnt - ur_base, 0);

    // ---- underrun ----
    rx_base = rx_wr; ur_base = ur_cnt;
    check("under_tx_ready", tx_ready, 1);
    m_tx[0] = 8'hA1; m_tx[1] = 8'h5E;
    fork
      spi_frame(2, HALF, 0);
      begin
        wait_clks(40);
        push_tx(8'h5A);
      end
    join
    check("under_miso0", m_rx[0], 8'h00);
    check("under_miso1", m_rx[1], 8'h5A);
    check("under_count", ur_cnt - ur_base, 1);
    check("under_rx0", rx_log[rx_base], 8'hA1);
    check("under_rx1", rx_log[rx_base+1], 8'h5E);

    // ---- abort after 5 bits ----
    rx_base = rx_wr; ur_base = ur_cnt;
    push_tx(8'h77);
    m_tx[0] = 8'hC3;
    fork
      spi_frame(1, HALF, 5);
      begin
        wait_clks(40);
        push_tx(8'h3E);
      end
    join
    tmp = m_rx[0];
    check("abort_partial_miso", tmp[7:3], 5'b01110);
    check("abort_rx_count", rx_wr - rx_base, 0);
    check("abort_miso_oe", miso_oe, 0);
    check("abort_busy", busy, 0);
    check("abort_miso", miso, 0);
    check("abort_buffer_kept", tx_ready, 0);
    m_tx[0] = 8'h42;
    spi_frame(1, HALF, 0);
    check("abort_next_miso", m_rx[0], 8'h3E);
    check("abort_next_rx", rx_log[rx_base], 8'h42);
    check("abort_underrun", ur_cnt - ur_base, 0);

    // ---- reset mid-transfer ----
    push_tx(8'hC4);
    cs_n = 1'b0;
    wait_clks(8);
    push_tx(8'hD2);
    for (int i = 0; i < 4; i++) sclk_bit(1'b1, HALF, cap_dummy);
    check("midrst_busy_before", busy, 1);
    check("midrst_ready_before", tx_ready, 0);
    reset = 1'b0;
    #1;
    check("midrst_miso", miso, 0);
    check("midrst_miso_oe", miso_oe, 0);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_underrun", tx_underrun, 0);
    check("midrst_busy", busy, 0);
    sclk = 1'b0;
    cs_n = 1'b1;
    wait_clks(4);
    reset = 1'b1;
    wait_clks(4);
    rx_base = rx_wr; ur_base = ur_cnt;
    push_tx(8'h96);
    m_tx[0] = 8'h69;
    spi_frame(1, HALF, 0);
    check("midrst_fresh_miso", m_rx[0], 8'h96);
    check("midrst_fresh_rx_count", rx_wr - rx_base, 1);
    check("midrst_fresh_rx", rx_log[rx_base], 8'h69);

    // ---- minimum timing, 32 random words in one window ----
    rx_base = rx_wr; ur_base = ur_cnt;
    for (int i = 0; i < 32; i++) begin
      m_tx[i]   = DW'($urandom_range(0, 255));
      exp_tx[i] = DW'($urandom_range(0, 255));
    end
    push_tx(exp_tx[0]);
    fork
      spi_frame(32, SYNC + 3, 0);
      begin
        for (int i = 1; i < 32; i++) push_tx(exp_tx[i]);
      end
    join
    check("mint_rx_count", rx_wr - rx_base, 32);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("mint_rx%0d", i), rx_log[rx_base+i], m_tx[i]);
      check($sformatf("mint_miso%0d", i), m_rx[i], exp_tx[i]);
    end
    check("mint_underrun", ur_cnt - ur_base, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
